uart_trx_core: RTL and testbench
================================

// Module: uart_trx_core
// PURPOSE
//  Byte-oriented UART transceiver core: start-edge detector, 8N1 receiver and
//  multi-byte 8N1 transmitter. The board-level UART wrapper sits above it and
//  echoes a check word on each received byte or streams a data word on request.
//  Covers the roles of the start-edge detector, the RX control and the TX control.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per UART bit (50 MHz / 9600 baud); must be >= 4
// PORTS
//  clk          in   1   single clock; all logic on rising edge
//  rst_n        in   1   synchronous reset, active-high (asserted = 1)
//  rx_pin_in    in   1   asynchronous serial input, idle high
//  h2l_sig      out  1   1-cycle pulse on synchronized high->low of rx_pin_in
//  rx_data      out  8   last correctly framed received byte
//  rx_done_sig  out  1   1-cycle pulse when rx_data is updated
//  tx_sig       in   1   transmit request; a 0->1 edge starts a burst
//  tx_data      in   64  burst payload; byte k = tx_data[8k+7:8k]
//  len          in   4   number of bytes in the burst (0..8)
//  tx_pin_out   out  1   serial output, idle high
//  tx_busy      out  1   high while a burst is in progress
// BEHAVIOUR
//  Reset (sync, rst_n=1): h2l_sig=0, rx_data=8'h00, rx_done_sig=0, tx_pin_out=1,
//   tx_busy=0. Synchronizer flops=1. Both FSMs go to IDLE.
//   A reset mid-frame aborts it: no rx_done_sig; tx_pin_out=1 after the next edge.
//  Edge detect: rx_pin_in passes through a 2-flop synchronizer, then a history flop.
//   h2l_sig=1 for exactly one cycle when history=1 and synced=0.
//  RX FSM IDLE->START->DATA->STOP->IDLE. h2l_sig is honoured only in IDLE.
//   START: sample at CLKS_PER_BIT/2; sample 1 = glitch -> IDLE, no output.
//   DATA: 8 samples, each CLKS_PER_BIT after the previous; LSB first.
//   STOP: sample one bit later. If 1: rx_data<=byte, rx_done_sig=1 for one cycle.
//     If 0 (framing error): byte dropped, no pulse. Both cases return to IDLE.
//   The next h2l_sig is accepted from the cycle after the return to IDLE.
//  TX trigger: registered edge detect on tx_sig (prev reset 0). A rising edge
//   seen in TX IDLE latches tx_data and len. tx_sig rising while busy is ignored.
//   A held-high tx_sig does not retrigger.
//  Burst length: len=0 -> nothing sent, tx_busy stays 0. len>8 -> clamped to 8.
//  TX FSM IDLE->START->DATA->STOP->(next byte START | IDLE):
//   tx_pin_out drives 0 the cycle after the edge is registered.
//   Each bit lasts exactly CLKS_PER_BIT cycles.
//   Frame = start 0, 8 data bits LSB first, stop 1.
//   Bytes are sent byte 0 first, back-to-back with no idle between frames.
//   tx_busy rises with the first start bit. It falls when the last stop bit
//   completes; that same cycle is IDLE and accepts a new edge.
//  RX and TX are fully independent; simultaneous activity is supported.
//  Registered outputs only; no combinational path from inputs to outputs.
// TESTING (CLKS_PER_BIT=16)
//  RX 8'hA5 framed correctly -> exactly one rx_done_sig pulse, rx_data=8'hA5,
//   pulse at 9.5 bit-times (+/- sync latency) after the falling edge.
//  rx_pin_in low pulse of 4 cycles -> one h2l_sig pulse, START aborts,
//   no rx_done_sig, rx_data unchanged.
//  RX 8'h3C with stop bit 0 -> no rx_done_sig, rx_data keeps its previous value.
//  tx_data=64'h0807060504030201, len=8, tx_sig rise -> line decodes 01..08.
//   Burst lasts 8*10*16=1280 cycles; tx_busy high that whole time.
//  len=4, tx_data[31:0]=32'hDEADBEEF -> EF,BE,AD,DE sent.
//   A second tx_sig rise mid-burst is ignored; len=0 -> line stays high.
//  Assert rst_n during a TX data bit and an RX data bit -> tx_pin_out=1 next cycle.
//   Then rx_done_sig=0, tx_busy=0; a fresh 8'h55 RX/TX then works.

Source files
------------

// File: rtl/uart_trx_core.sv
// uart_trx_core
//   Byte-oriented UART transceiver core: a start-edge detector, an 8N1
//   receiver and a multi-byte 8N1 transmitter.
//
//   Ports
//     clk          single clock, rising edge
//     rst_n        synchronous reset, active-high despite the name
//     rx_pin_in    asynchronous serial input, idle high
//     h2l_sig      1-cycle pulse on a synchronized high->low of rx_pin_in
//     rx_data      last correctly framed received byte
//     rx_done_sig  1-cycle pulse when rx_data is updated
//     tx_sig       transmit request, a 0->1 edge starts a burst
//     tx_data      burst payload, byte k = tx_data[8k+7:8k]
//     len          bytes in the burst (0 = nothing, >8 clamped to 8)
//     tx_pin_out   serial output, idle high
//     tx_busy      high while a burst is in progress
module uart_trx_core #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_pin_in,
   output logic        h2l_sig,
   output logic [7:0]  rx_data,
   output logic        rx_done_sig,
   input  logic        tx_sig,
   input  logic [63:0] tx_data,
   input  logic [3:0]  len,
   output logic        tx_pin_out,
   output logic        tx_busy
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // ------------------------------------------------------------------
   // Start-edge detector: 2-flop synchronizer plus a history flop.
   // ------------------------------------------------------------------
   logic sync1_reg, sync2_reg, hist_reg, h2l_reg;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         hist_reg  <= 1'b1;
         h2l_reg   <= 1'b0;
      end else begin
         sync1_reg <= rx_pin_in;
         sync2_reg <= sync1_reg;
         hist_reg  <= sync2_reg;
         h2l_reg   <= hist_reg & ~sync2_reg;
      end
   end

   assign h2l_sig = h2l_reg;

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   state_t          rx_state_reg, rx_state_next;
   logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
   logic [2:0]      rx_bit_reg, rx_bit_next;
   logic [7:0]      rx_shift_reg, rx_shift_next;
   logic [7:0]      rx_data_reg, rx_data_next;
   logic            rx_done_reg, rx_done_next;
   logic            rx_tick, rx_half;

   assign rx_tick = (rx_cnt_reg == CW'(CLKS_PER_BIT - 1));
   assign rx_half = (rx_cnt_reg == CW'(HALF - 1));

   always_ff @(posedge clk) begin
      if (rst_n) begin
         rx_state_reg <= S_IDLE;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
         rx_data_reg  <= '0;
         rx_done_reg  <= 1'b0;
      end else begin
         rx_state_reg <= rx_state_next;
         rx_cnt_reg   <= rx_cnt_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
         rx_data_reg  <= rx_data_next;
         rx_done_reg  <= rx_done_next;
      end
   end

   always_comb begin
      rx_state_next = rx_state_reg;
      case (rx_state_reg)
         S_IDLE:  if (h2l_reg) rx_state_next = S_START;
         // A line that is high again at mid start bit was a glitch.
         S_START: if (rx_half) rx_state_next = sync2_reg ? S_IDLE : S_DATA;
         S_DATA:  if (rx_tick && rx_bit_reg == 3'd7) rx_state_next = S_STOP;
         S_STOP:  if (rx_tick) rx_state_next = S_IDLE;
         default: rx_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      rx_cnt_next   = rx_cnt_reg + CW'(1);
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_data_next  = rx_data_reg;
      rx_done_next  = 1'b0;
      case (rx_state_reg)
         S_IDLE: begin
            rx_cnt_next = '0;
            rx_bit_next = '0;
         end
         S_START: begin
            if (rx_half) rx_cnt_next = '0;
         end
         S_DATA: begin
            if (rx_tick) begin
               rx_cnt_next   = '0;
               rx_shift_next = {sync2_reg, rx_shift_reg[7:1]};
               rx_bit_next   = rx_bit_reg + 3'd1;
            end
         end
         S_STOP: begin
            if (rx_tick) begin
               rx_cnt_next = '0;
               // A low stop bit is a framing error: drop the byte silently.
               if (sync2_reg) begin
                  rx_data_next = rx_shift_reg;
                  rx_done_next = 1'b1;
               end
            end
         end
         default: rx_cnt_next = '0;
      endcase
   end

   assign rx_data     = rx_data_reg;
   assign rx_done_sig = rx_done_reg;

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   state_t          tx_state_reg, tx_state_next;
   logic [CW-1:0]   tx_cnt_reg, tx_cnt_next;
   logic [2:0]      tx_bit_reg, tx_bit_next;
   logic [3:0]      tx_left_reg, tx_left_next;
   logic [63:0]     tx_shift_reg, tx_shift_next;
   logic            tx_pin_reg, tx_pin_next;
   logic            tx_busy_reg, tx_busy_next;
   logic            tx_prev_reg;
   logic            tx_tick, tx_rise;
   logic [3:0]      len_clamped;

   assign tx_tick     = (tx_cnt_reg == CW'(CLKS_PER_BIT - 1));
   assign tx_rise     = tx_sig & ~tx_prev_reg;
   assign len_clamped = (len > 4'd8) ? 4'd8 : len;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         tx_state_reg <= S_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_left_reg  <= '0;
         tx_shift_reg <= '0;
         tx_pin_reg   <= 1'b1;
         tx_busy_reg  <= 1'b0;
         tx_prev_reg  <= 1'b0;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_cnt_reg   <= tx_cnt_next;
         tx_bit_reg   <= tx_bit_next;
         tx_left_reg  <= tx_left_next;
         tx_shift_reg <= tx_shift_next;
         tx_pin_reg   <= tx_pin_next;
         tx_busy_reg  <= tx_busy_next;
         tx_prev_reg  <= tx_sig;
      end
   end

   always_comb begin
      tx_state_next = tx_state_reg;
      case (tx_state_reg)
         S_IDLE:  if (tx_rise && len != 4'd0) tx_state_next = S_START;
         S_START: if (tx_tick) tx_state_next = S_DATA;
         S_DATA:  if (tx_tick && tx_bit_reg == 3'd7) tx_state_next = S_STOP;
         // Back-to-back frames: the next start bit follows the stop bit directly.
         S_STOP:  if (tx_tick) tx_state_next = (tx_left_reg == 4'd1) ? S_IDLE : S_START;
         default: tx_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      tx_cnt_next   = tx_cnt_reg + CW'(1);
      tx_bit_next   = tx_bit_reg;
      tx_left_next  = tx_left_reg;
      tx_shift_next = tx_shift_reg;
      case (tx_state_reg)
         S_IDLE: begin
            tx_cnt_next = '0;
            tx_bit_next = '0;
            if (tx_rise && len != 4'd0) begin
               tx_shift_next = tx_data;
               tx_left_next  = len_clamped;
            end
         end
         S_START: begin
            if (tx_tick) tx_cnt_next = '0;
         end
         S_DATA: begin
            if (tx_tick) begin
               tx_cnt_next = '0;
               tx_bit_next = tx_bit_reg + 3'd1;
            end
         end
         S_STOP: begin
            if (tx_tick) begin
               tx_cnt_next   = '0;
               tx_left_next  = tx_left_reg - 4'd1;
               tx_shift_next = {8'h00, tx_shift_reg[63:8]};
            end
         end
         default: tx_cnt_next = '0;
      endcase

      // Line level and busy are derived from the next state so that both
      // outputs come straight from flops and change together with the state.
      tx_busy_next = (tx_state_next != S_IDLE);
      case (tx_state_next)
         S_START: tx_pin_next = 1'b0;
         S_DATA:  tx_pin_next = tx_shift_next[{3'b000, tx_bit_next}];
         default: tx_pin_next = 1'b1;
      endcase
   end

   assign tx_pin_out = tx_pin_reg;
   assign tx_busy    = tx_busy_reg;

endmodule

// File: tb/tb_uart_trx_core.sv
// tb_uart_trx_core
//   Scoreboard bench for uart_trx_core at CLKS_PER_BIT=16. Stimulus pushes
//   expected bytes into rx_q / tx_q; the RX monitor pops on rx_done_sig and
//   a line decoder on tx_pin_out pops at each decoded stop bit.
module tb_uart_trx_core;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        rx_pin_in = 1'b1;
   logic        tx_sig = 1'b0;
   logic [63:0] tx_data = '0;
   logic [3:0]  len = '0;
   logic        h2l_sig, rx_done_sig, tx_pin_out, tx_busy;
   logic [7:0]  rx_data;

   uart_trx_core #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst_n(rst_n), .rx_pin_in(rx_pin_in), .h2l_sig(h2l_sig),
      .rx_data(rx_data), .rx_done_sig(rx_done_sig), .tx_sig(tx_sig),
      .tx_data(tx_data), .len(len), .tx_pin_out(tx_pin_out), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rx_fall_cyc = 0;
   int h2l_count = 0;
   int done_count = 0;
   int busy_cycles = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // RX monitor
   logic [7:0] rx_exp;
   int         rx_lat;
   always @(negedge clk) begin
      if (h2l_sig) h2l_count++;
      if (tx_busy) busy_cycles++;
      if (rx_done_sig) begin
         done_count++;
         if (rx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got pulse with rx_data=%0h, expected no pulse", rx_data);
         end else begin
            rx_exp = rx_q.pop_front();
            chk("rx_byte", {56'd0, rx_data}, {56'd0, rx_exp});
            rx_lat = cyc - rx_fall_cyc;
            checks++;
            if (rx_lat < 148 || rx_lat > 164) begin
               errors++;
               $display("FAIL rx_latency: got %0d cycles, expected 148..164", rx_lat);
            end
            $display("RX byte %02h latency %0d", rx_data, rx_lat);
         end
      end
   end

   // TX line decoder: samples mid-bit relative to the detected start edge.
   logic       dec_active = 1'b0;
   int         dec_cnt = 0;
   int         dec_k;
   logic [7:0] dec_byte = '0;
   logic [7:0] tx_exp;
   always @(negedge clk) begin
      if (rst_n) begin
         dec_active = 1'b0;
      end else if (!dec_active) begin
         if (!tx_pin_out) begin
            dec_active = 1'b1;
            dec_cnt = 0;
         end
      end else begin
         dec_cnt++;
         if (dec_cnt >= CPB/2 + CPB && (dec_cnt - CPB/2) % CPB == 0) begin
            dec_k = (dec_cnt - CPB/2) / CPB;
            if (dec_k <= 8) begin
               dec_byte[dec_k-1] = tx_pin_out;
            end else begin
               chk("tx_stop_bit", {63'd0, tx_pin_out}, 64'd1);
               if (tx_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got byte %02h, expected no frame", dec_byte);
               end else begin
                  tx_exp = tx_q.pop_front();
                  chk("tx_byte", {56'd0, dec_byte}, {56'd0, tx_exp});
               end
               $display("TX byte %02h", dec_byte);
               dec_active = 1'b0;
            end
         end
      end
   end

   task automatic rx_send(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx_pin_in = 1'b0;
      rx_fall_cyc = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_pin_in = stop;
      repeat (CPB) @(negedge clk);
      rx_pin_in = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic tx_start(input logic [63:0] d, input logic [3:0] l);
      @(negedge clk);
      tx_data = d;
      len = l;
      tx_sig = 1'b1;
      busy_cycles = 0;
   endtask

   task automatic wait_tx_idle(input string name);
      bit done;
      done = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3000 && !done; i++) begin
         if (!tx_busy) done = 1'b1;
         else @(negedge clk);
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s: tx_busy still 1 after 3000 cycles, expected 0", name);
      end
      repeat (2) @(negedge clk);
   endtask

   int h2l_before, done_before;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_h2l", {63'd0, h2l_sig}, 64'd0);
      chk("rst_rx_data", {56'd0, rx_data}, 64'h00);
      chk("rst_rx_done", {63'd0, rx_done_sig}, 64'd0);
      chk("rst_tx_pin", {63'd0, tx_pin_out}, 64'd1);
      chk("rst_tx_busy", {63'd0, tx_busy}, 64'd0);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);

      // Good frame A5
      rx_q.push_back(8'hA5);
      rx_send(8'hA5, 1'b1);
      repeat (10) @(negedge clk);
      chk("rx_a5_count", done_count, 1);

      // 4-cycle glitch
      h2l_before = h2l_count;
      @(negedge clk);
      rx_pin_in = 1'b0;
      repeat (4) @(negedge clk);
      rx_pin_in = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_h2l", h2l_count - h2l_before, 1);
      chk("glitch_done", done_count, 1);
      chk("glitch_rx_data", {56'd0, rx_data}, 64'hA5);

      // Framing error: 3C with low stop bit
      rx_send(8'h3C, 1'b0);
      repeat (20) @(negedge clk);
      chk("frame_err_done", done_count, 1);
      chk("frame_err_rx_data", {56'd0, rx_data}, 64'hA5);

      // 8-byte burst, tx_sig then held high
      for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
      tx_start(64'h0807060504030201, 4'd8);
      wait_tx_idle("burst8_end");
      chk("burst8_busy_cycles", busy_cycles, 1280);
      repeat (100) @(negedge clk);
      chk("held_high_no_retrigger", {63'd0, tx_busy}, 64'd0);
      tx_sig = 1'b0;

      // 4-byte burst with ignored mid-burst rise, concurrent RX 5A
      tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
      tx_q.push_back(8'hAD); tx_q.push_back(8'hDE);
      rx_q.push_back(8'h5A);
      fork
         rx_send(8'h5A, 1'b1);
         begin
            tx_start(64'h11223344DEADBEEF, 4'd4);
            repeat (200) @(negedge clk);
            tx_sig = 1'b0;
            @(negedge clk);
            tx_data = 64'hFFFF_FFFF_FFFF_FFFF;
            len = 4'd8;
            tx_sig = 1'b1;
            wait_tx_idle("burst4_end");
         end
      join
      chk("burst4_busy_cycles", busy_cycles, 640);
      tx_sig = 1'b0;

      // len = 0
      tx_start(64'hFF, 4'd0);
      repeat (50) @(negedge clk);
      chk("len0_busy", busy_cycles, 0);
      chk("len0_line", {63'd0, tx_pin_out}, 64'd1);
      tx_sig = 1'b0;

      // len > 8 is clamped
      tx_q.push_back(8'h88); tx_q.push_back(8'h77); tx_q.push_back(8'h66); tx_q.push_back(8'h55);
      tx_q.push_back(8'h44); tx_q.push_back(8'h33); tx_q.push_back(8'h22); tx_q.push_back(8'h11);
      tx_start(64'h1122334455667788, 4'd12);
      wait_tx_idle("clamp_end");
      chk("clamp_busy_cycles", busy_cycles, 1280);
      tx_sig = 1'b0;

      // Reset during a TX data bit and an RX data bit
      done_before = done_count;
      tx_start(64'h0000_0000_0000_C3C3, 4'd2);
      rx_pin_in = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      tx_sig = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_tx_pin", {63'd0, tx_pin_out}, 64'd1);
      chk("midrst_tx_busy", {63'd0, tx_busy}, 64'd0);
      chk("midrst_rx_done", {63'd0, rx_done_sig}, 64'd0);
      chk("midrst_rx_data", {56'd0, rx_data}, 64'h00);
      rst_n = 1'b0;
      rx_pin_in = 1'b1;
      repeat (200) @(negedge clk);
      chk("postrst_no_done", done_count - done_before, 0);
      chk("postrst_tx_busy", {63'd0, tx_busy}, 64'd0);

      // Fresh 55 on both directions
      rx_q.push_back(8'h55);
      tx_q.push_back(8'h55);
      fork
         rx_send(8'h55, 1'b1);
         begin
            tx_start(64'h55, 4'd1);
            wait_tx_idle("fresh55_end");
            tx_sig = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      chk("fresh55_rx_data", {56'd0, rx_data}, 64'h55);
      chk("rx_queue_empty", rx_q.size(), 0);
      chk("tx_queue_empty", tx_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
